// File: rtl/complex_mult_pkg.sv
// Shared sizing helpers for the pipelined complex multiplier.
// Field offsets locate a, b, c and d inside the packed {a,b,c,d} operand word.
package complex_mult_pkg;

  function automatic int res_width(input int w);
    return 2 * w + 2;
  endfunction

  function automatic int a_lsb(input int w);
    return 3 * w;
  endfunction

  function automatic int b_lsb(input int w);
    return 2 * w;
  endfunction

  function automatic int c_lsb(input int w);
    return w;
  endfunction

  function automatic int d_lsb(input int w);
    return 0 * w;
  endfunction

endpackage

// File: rtl/cnm_smult.sv
// Combinational signed multiplier producing an exact 2*W-bit product.
module cnm_smult #(
  parameter int W = 9
) (
  input  logic signed [W-1:0]   a_i,
  input  logic signed [W-1:0]   b_i,
  output logic signed [2*W-1:0] p_o
);

  assign p_o = (2*W)'(a_i) * (2*W)'(b_i);

endmodule

// File: rtl/complex_nr_mult_pipe.sv
// Three-stage elastic complex multiplier: x*y or x*conj(y), one result per cycle.
// Each stage advances when its successor is empty or advancing, so bubbles collapse.
module complex_nr_mult_pipe
  import complex_mult_pkg::*;
#(
  parameter int DATA_WIDTH = 8,
  parameter bit SIGNED     = 1'b0,
  localparam int RES_WIDTH = res_width(DATA_WIDTH)
) (
  input  logic                     clk,
  input  logic                     rstn,
  input  logic                     sw_rst,
  input  logic                     op_val,
  output logic                     op_ready,
  input  logic [4*DATA_WIDTH-1:0]  op_data,
  input  logic                     op_conj,
  input  logic                     res_ready,
  output logic                     res_val,
  output logic [2*RES_WIDTH-1:0]   res_data,
  output logic                     busy
);

  localparam int W     = DATA_WIDTH;
  localparam int EW    = W + 1;
  localparam int RW    = RES_WIDTH;
  localparam int A_LSB = a_lsb(W);
  localparam int B_LSB = b_lsb(W);
  localparam int C_LSB = c_lsb(W);
  localparam int D_LSB = d_lsb(W);

  logic s0_v_q, s0_v_d;
  logic s0_conj_q, s0_conj_d;
  logic [W-1:0] a_q, a_d, b_q, b_d, c_q, c_d, d_q, d_d;

  logic s1_v_q, s1_v_d;
  logic s1_conj_q, s1_conj_d;
  logic signed [RW-1:0] p_ac_q, p_ac_d, p_bd_q, p_bd_d;
  logic signed [RW-1:0] p_ad_q, p_ad_d, p_bc_q, p_bc_d;

  logic s2_v_q, s2_v_d;
  logic signed [RW-1:0] re_q, re_d, im_q, im_d;

  logic adv0, adv1, adv2, accept;

  logic signed [EW-1:0] a_x, b_x, c_x, d_x;
  logic signed [RW-1:0] p_ac, p_bd, p_ad, p_bc;

  assign adv2     = s2_v_q & res_ready;
  assign adv1     = s1_v_q & (~s2_v_q | adv2);
  assign adv0     = s0_v_q & (~s1_v_q | adv1);
  assign op_ready = ~s0_v_q | adv0;
  assign accept   = op_val & op_ready;

  // One extra bit lets unsigned operands share the signed multiplier.
  assign a_x = SIGNED ? {a_q[W-1], a_q} : {1'b0, a_q};
  assign b_x = SIGNED ? {b_q[W-1], b_q} : {1'b0, b_q};
  assign c_x = SIGNED ? {c_q[W-1], c_q} : {1'b0, c_q};
  assign d_x = SIGNED ? {d_q[W-1], d_q} : {1'b0, d_q};

  cnm_smult #(.W(EW)) u_mul_ac (.a_i(a_x), .b_i(c_x), .p_o(p_ac));
  cnm_smult #(.W(EW)) u_mul_bd (.a_i(b_x), .b_i(d_x), .p_o(p_bd));
  cnm_smult #(.W(EW)) u_mul_ad (.a_i(a_x), .b_i(d_x), .p_o(p_ad));
  cnm_smult #(.W(EW)) u_mul_bc (.a_i(b_x), .b_i(c_x), .p_o(p_bc));

  always_comb begin
    s0_v_d    = s0_v_q;
    s0_conj_d = s0_conj_q;
    a_d       = a_q;
    b_d       = b_q;
    c_d       = c_q;
    d_d       = d_q;
    if (accept) begin
      s0_v_d    = 1'b1;
      s0_conj_d = op_conj;
      a_d       = op_data[A_LSB +: W];
      b_d       = op_data[B_LSB +: W];
      c_d       = op_data[C_LSB +: W];
      d_d       = op_data[D_LSB +: W];
    end else if (adv0) begin
      s0_v_d = 1'b0;
    end
  end

  always_comb begin
    s1_v_d    = s1_v_q;
    s1_conj_d = s1_conj_q;
    p_ac_d    = p_ac_q;
    p_bd_d    = p_bd_q;
    p_ad_d    = p_ad_q;
    p_bc_d    = p_bc_q;
    if (adv0) begin
      s1_v_d    = 1'b1;
      s1_conj_d = s0_conj_q;
      p_ac_d    = p_ac;
      p_bd_d    = p_bd;
      p_ad_d    = p_ad;
      p_bc_d    = p_bc;
    end else if (adv1) begin
      s1_v_d = 1'b0;
    end
  end

  // Result width leaves headroom for the sum of two full products.
  always_comb begin
    s2_v_d = s2_v_q;
    re_d   = re_q;
    im_d   = im_q;
    if (adv1) begin
      s2_v_d = 1'b1;
      re_d   = s1_conj_q ? (p_ac_q + p_bd_q) : (p_ac_q - p_bd_q);
      im_d   = s1_conj_q ? (p_bc_q - p_ad_q) : (p_ad_q + p_bc_q);
    end else if (adv2) begin
      s2_v_d = 1'b0;
    end
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      s0_v_q    <= 1'b0;
      s0_conj_q <= 1'b0;
      a_q       <= '0;
      b_q       <= '0;
      c_q       <= '0;
      d_q       <= '0;
      s1_v_q    <= 1'b0;
      s1_conj_q <= 1'b0;
      p_ac_q    <= '0;
      p_bd_q    <= '0;
      p_ad_q    <= '0;
      p_bc_q    <= '0;
      s2_v_q    <= 1'b0;
      re_q      <= '0;
      im_q      <= '0;
    end else if (sw_rst) begin
      s0_v_q    <= 1'b0;
      s0_conj_q <= 1'b0;
      a_q       <= '0;
      b_q       <= '0;
      c_q       <= '0;
      d_q       <= '0;
      s1_v_q    <= 1'b0;
      s1_conj_q <= 1'b0;
      p_ac_q    <= '0;
      p_bd_q    <= '0;
      p_ad_q    <= '0;
      p_bc_q    <= '0;
      s2_v_q    <= 1'b0;
      re_q      <= '0;
      im_q      <= '0;
    end else begin
      s0_v_q    <= s0_v_d;
      s0_conj_q <= s0_conj_d;
      a_q       <= a_d;
      b_q       <= b_d;
      c_q       <= c_d;
      d_q       <= d_d;
      s1_v_q    <= s1_v_d;
      s1_conj_q <= s1_conj_d;
      p_ac_q    <= p_ac_d;
      p_bd_q    <= p_bd_d;
      p_ad_q    <= p_ad_d;
      p_bc_q    <= p_bc_d;
      s2_v_q    <= s2_v_d;
      re_q      <= re_d;
      im_q      <= im_d;
    end
  end

  assign res_val  = s2_v_q;
  assign res_data = {re_q, im_q};
  assign busy     = s0_v_q | s1_v_q | s2_v_q;

endmodule

// File: tb/tb_complex_nr_mult_pipe.sv
// Directed bench for complex_nr_mult_pipe with a result scoreboard per instance.
// An unsigned and a signed instance share clock and resets.
module tb_complex_nr_mult_pipe;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rstn, sw_rst;
  logic        op_val, op_conj, res_ready, op_ready, res_val, busy;
  logic [31:0] op_data;
  logic [35:0] res_data;

  logic        s_op_val, s_op_conj, s_res_ready, s_op_ready, s_res_val, s_busy;
  logic [31:0] s_op_data;
  logic [35:0] s_res_data;

  int total = 0;
  int bad   = 0;
  logic [35:0] q[$];
  logic [35:0] sq[$];

  complex_nr_mult_pipe #(.DATA_WIDTH(8), .SIGNED(1'b0)) u_dut (
    .clk(clk), .rstn(rstn), .sw_rst(sw_rst),
    .op_val(op_val), .op_ready(op_ready), .op_data(op_data), .op_conj(op_conj),
    .res_ready(res_ready), .res_val(res_val), .res_data(res_data), .busy(busy)
  );

  complex_nr_mult_pipe #(.DATA_WIDTH(8), .SIGNED(1'b1)) u_sdut (
    .clk(clk), .rstn(rstn), .sw_rst(sw_rst),
    .op_val(s_op_val), .op_ready(s_op_ready), .op_data(s_op_data), .op_conj(s_op_conj),
    .res_ready(s_res_ready), .res_val(s_res_val), .res_data(s_res_data), .busy(s_busy)
  );

  // Reference result {re,im} computed with wide integers.
  function automatic logic [35:0] model(input logic [31:0] d, input bit conj, input bit sgn);
    longint a, b, c, e, re, im;
    a = sgn ? longint'($signed(d[31:24])) : longint'(d[31:24]);
    b = sgn ? longint'($signed(d[23:16])) : longint'(d[23:16]);
    c = sgn ? longint'($signed(d[15:8]))  : longint'(d[15:8]);
    e = sgn ? longint'($signed(d[7:0]))   : longint'(d[7:0]);
    re = conj ? (a * c + b * e) : (a * c - b * e);
    im = conj ? (b * c - a * e) : (a * e + b * c);
    return {re[17:0], im[17:0]};
  endfunction

  task automatic checkOutput(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("[TB] FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic popCompare(input string tag, ref logic [35:0] sb[$], input logic [35:0] obs);
    total++;
    assert (sb.size() != 0) else begin
      bad++;
      $error("[TB] FAIL %s observed=unexpected result %0h expected=no result", tag, obs);
    end
    if (sb.size() != 0) checkOutput(tag, obs, sb.pop_front());
  endtask

  // One clock: sample handshakes mid-cycle, then return just after the rising edge.
  task automatic tick();
    @(negedge clk);
    if (!rstn || sw_rst) begin
      q.delete();
      sq.delete();
    end else begin
      if (op_val && op_ready)     q.push_back(model(op_data, op_conj, 1'b0));
      if (s_op_val && s_op_ready) sq.push_back(model(s_op_data, s_op_conj, 1'b1));
      if (res_val && res_ready)       popCompare("sb_unsigned", q, res_data);
      if (s_res_val && s_res_ready)   popCompare("sb_signed", sq, s_res_data);
    end
    @(posedge clk);
    #1;
  endtask

  task automatic applyStimulus(input logic [31:0] d, input bit cj);
    op_data = d;
    op_conj = cj;
    op_val  = 1'b1;
  endtask

  task automatic singleBeat(input string tag, input logic [31:0] d, input bit cj, input logic [35:0] exp);
    applyStimulus(d, cj);
    tick();
    op_val = 1'b0;
    checkOutput({tag, "_lat1"}, res_val, 1'b0);
    tick();
    checkOutput({tag, "_lat2"}, res_val, 1'b0);
    tick();
    checkOutput({tag, "_lat3"}, res_val, 1'b1);
    checkOutput({tag, "_data"}, res_data, exp);
    tick();
  endtask

  initial begin
    rstn = 1'b1; sw_rst = 1'b0;
    op_val = 1'b0; op_conj = 1'b0; op_data = '0; res_ready = 1'b1;
    s_op_val = 1'b0; s_op_conj = 1'b0; s_op_data = '0; s_res_ready = 1'b1;
    #2 rstn = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    checkOutput("rst_res_val", res_val, 1'b0);
    checkOutput("rst_busy", busy, 1'b0);
    checkOutput("rst_res_data", res_data, 36'h0);
    checkOutput("rst_op_ready", op_ready, 1'b1);
    rstn = 1'b1;
    tick();

    $display("[TB] unsigned x*y and x*conj(y)");
    singleBeat("mul", {8'd3, 8'd4, 8'd5, 8'd6}, 1'b0, {18'h3FFF7, 18'd38});
    singleBeat("conj", {8'd3, 8'd4, 8'd5, 8'd6}, 1'b1, {18'd39, 18'd2});

    $display("[TB] extreme operands");
    applyStimulus(32'hFFFF_FFFF, 1'b0);
    s_op_data = 32'h8080_807F; s_op_conj = 1'b0; s_op_val = 1'b1;
    tick();
    op_val = 1'b0; s_op_val = 1'b0;
    tick();
    tick();
    checkOutput("ext_u_val", res_val, 1'b1);
    checkOutput("ext_s_val", s_res_val, 1'b1);
    checkOutput("ext_u_data", res_data, {18'd0, 18'd130050});
    checkOutput("ext_s_data", s_res_data, {18'd32640, 18'd128});
    tick();

    $display("[TB] back-pressure fill and drain");
    res_ready = 1'b0;
    for (int i = 0; i < 3; i++) begin
      applyStimulus($urandom, (i % 2) == 1);
      checkOutput("fill_ready", op_ready, 1'b1);
      tick();
    end
    applyStimulus($urandom, 1'b1);
    for (int i = 0; i < 2; i++) begin
      checkOutput("full_ready", op_ready, 1'b0);
      checkOutput("full_val", res_val, 1'b1);
      checkOutput("held_data", res_data, q[0]);
      tick();
    end
    res_ready = 1'b1;
    checkOutput("drain_val0", res_val, 1'b1);
    tick();
    applyStimulus($urandom, 1'b0);
    checkOutput("drain_val1", res_val, 1'b1);
    tick();
    op_val = 1'b0;
    for (int i = 0; i < 3; i++) begin
      checkOutput("drain_gap", res_val, 1'b1);
      tick();
    end
    checkOutput("drain_busy", busy, 1'b0);
    checkOutput("drain_sb", q.size(), 0);

    $display("[TB] software reset with beats in flight");
    res_ready = 1'b0;
    for (int i = 0; i < 3; i++) begin
      applyStimulus($urandom, 1'b0);
      tick();
    end
    applyStimulus($urandom, 1'b1);
    res_ready = 1'b1;
    sw_rst = 1'b1;
    tick();
    sw_rst = 1'b0;
    op_val = 1'b0;
    checkOutput("swr_res_val", res_val, 1'b0);
    checkOutput("swr_busy", busy, 1'b0);
    checkOutput("swr_res_data", res_data, 36'h0);
    checkOutput("swr_op_ready", op_ready, 1'b1);
    singleBeat("post_swr", {8'd1, 8'd2, 8'd3, 8'd4}, 1'b0, {18'h3FFFB, 18'd10});

    $display("[TB] asynchronous reset mid-stream");
    for (int i = 0; i < 4; i++) begin
      applyStimulus($urandom, (i % 2) == 0);
      tick();
    end
    op_val = 1'b0;
    #1 rstn = 1'b0;
    #1;
    checkOutput("arst_res_val", res_val, 1'b0);
    checkOutput("arst_busy", busy, 1'b0);
    checkOutput("arst_res_data", res_data, 36'h0);
    tick();
    rstn = 1'b1;
    for (int i = 0; i < 6; i++) begin
      applyStimulus($urandom, (i % 3) == 0);
      checkOutput("tput_ready", op_ready, 1'b1);
      tick();
      if (i >= 2) checkOutput("tput_val", res_val, 1'b1);
    end
    op_val = 1'b0;
    for (int i = 0; i < 3; i++) begin
      checkOutput("tput_tail", res_val, 1'b1);
      tick();
    end
    checkOutput("end_busy", busy, 1'b0);
    checkOutput("end_sb", q.size(), 0);
    checkOutput("end_ssb", sq.size(), 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
